// File: rtl/rle_pixel_expander_pkg.sv
// Shared definitions for the RLE pixel expander: FSM encodings, default widths
// and the frame-size expression also used by the compressed-stream read counter.
package rle_pixel_expander_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_LEN = 3'd1,
      ST_GET_VAL = 3'd2,
      ST_EMIT    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // YUV 4:2:0 byte count at full precision; callers truncate to their address width.
   function automatic logic [33:0] frame_bytes(input logic [15:0] w, input logic [15:0] h);
      logic [33:0] prod;
      prod = 34'(w) * 34'(h) * 34'd3;
      return prod >> 1;
   endfunction

endpackage

// File: rtl/rle_pixel_expander_wr_addr_counter.sv
// Frame-buffer write address: zeroed at frame start, stepped per emitted pixel,
// and flags when the current address is the final byte of the frame.
module rle_pixel_expander_wr_addr_counter
   import rle_pixel_expander_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              i_load_zero,
   input  logic              i_incr,
   input  logic [ADDR_W-1:0] i_total,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_is_last
);

   logic [ADDR_W-1:0] r_addr;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_addr <= '0;
      end else if (i_load_zero) begin
         r_addr <= '0;
      end else if (i_incr) begin
         r_addr <= r_addr + ADDR_W'(1);
      end
   end

   assign o_addr    = r_addr;
   assign o_is_last = (r_addr == (i_total - ADDR_W'(1)));

endmodule

// File: rtl/rle_pixel_expander.sv
// Expands (length, value) byte pairs into a pixel byte stream with matching
// frame-buffer write addresses; reports frame completion and stream errors.
module rle_pixel_expander
   import rle_pixel_expander_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [15:0]       width,
   input  logic [15:0]       height,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              stream_done,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] w_addr,
   output logic              frame_done,
   output logic              err
);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_total;
   logic [DATA_W-1:0]   r_len;
   logic [DATA_W-1:0]   r_value;
   logic [DATA_W:0]     r_remaining;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_frame_done;
   logic                r_err;

   logic [ADDR_W-1:0]   w_total_calc;
   logic                w_start_ok;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_is_last;
   logic [ADDR_W-1:0]   w_cnt_addr;

   assign w_total_calc = ADDR_W'(frame_bytes(width, height));
   assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_in_fire    = in_valid && r_in_ready;
   assign w_out_fire   = (r_state == ST_EMIT) && out_ready;

   rle_pixel_expander_wr_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_wr_addr_counter (
      .clk         (clk),
      .clear       (clear),
      .i_load_zero (w_start_ok),
      .i_incr      (w_out_fire && !w_is_last),
      .i_total     (r_total),
      .o_addr      (w_cnt_addr),
      .o_is_last   (w_is_last)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state      <= ST_IDLE;
         r_total      <= '0;
         r_len        <= '0;
         r_value      <= '0;
         r_remaining  <= '0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) begin
                  r_err   <= 1'b0;
                  r_total <= w_total_calc;
                  if (w_total_calc == '0) begin
                     r_state      <= ST_DONE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_state      <= ST_GET_LEN;
                     r_frame_done <= 1'b0;
                     r_in_ready   <= 1'b1;
                  end
               end
            end
            ST_GET_LEN: begin
               if (w_in_fire) begin
                  r_len   <= in_data;
                  r_state <= ST_GET_VAL;
               end else if (stream_done) begin
                  r_err        <= 1'b1;
                  r_in_ready   <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= ST_DONE;
               end
            end
            ST_GET_VAL: begin
               if (w_in_fire) begin
                  r_value     <= in_data;
                  r_remaining <= {1'b0, r_len} + (DATA_W+1)'(1);
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
               end else if (stream_done) begin
                  r_err        <= 1'b1;
                  r_in_ready   <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= ST_DONE;
               end
            end
            ST_EMIT: begin
               // The frame end wins over the run end; leftover run pixels are dropped.
               if (w_out_fire) begin
                  if (w_is_last) begin
                     r_out_valid  <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_DONE;
                     if (r_remaining != (DATA_W+1)'(1)) begin
                        r_err <= 1'b1;
                     end
                  end else if (r_remaining == (DATA_W+1)'(1)) begin
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_state     <= ST_GET_LEN;
                  end else begin
                     r_remaining <= r_remaining - (DATA_W+1)'(1);
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_value;
   assign w_addr     = w_cnt_addr;
   assign frame_done = r_frame_done;
   assign err        = r_err;

endmodule

// File: tb/tb_rle_pixel_expander.sv
// Directed, table-driven bench for rle_pixel_expander with hand-computed pixel
// sequences, plus a hand-written mid-run clear sequence.
module tb_rle_pixel_expander;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              clear;
   logic              start;
   logic [15:0]       width;
   logic [15:0]       height;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              stream_done;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] w_addr;
   logic              frame_done;
   logic              err;

   always #5 clk = ~clk;

   rle_pixel_expander #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .width       (width),
      .height      (height),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .stream_done (stream_done),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .w_addr      (w_addr),
      .frame_done  (frame_done),
      .err         (err)
   );

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0]      w;
      logic [15:0]      h;
      int               nb;       // bytes available in the compressed stream
      logic [3:0][7:0]  b;        // b[0] is the first byte
      bit               sdone;    // raise stream_done once all bytes are taken
      bit               toggle;   // out_ready alternates 1/0
      int               exp_n;
      logic [7:0]       v0;
      int               split;    // pixels below this index carry v0, rest v1
      logic [7:0]       v1;
      bit               exp_err;
      int               exp_used;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0]        got_d[$];
      logic [ADDR_W-1:0] got_a[$];
      logic [3:0][7:0]   bytes;
      logic [7:0]        sd;
      logic [ADDR_W-1:0] sa;
      logic [7:0]        exp_d;
      int  used = 0;
      int  cyc = 0;
      int  after = 0;
      bit  done = 0;
      bit  last_hs = 0;
      bit  stall_pend = 0;
      bytes = v.b;
      @(posedge clk); #1;
      start = 1'b1; width = v.w; height = v.h;
      in_valid = 1'b0; out_ready = 1'b0; stream_done = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (after < 4 && cyc < 2000) begin
         if (cyc == 0) begin
            check("frame_done_post_start", {31'd0, frame_done}, {31'd0, (v.exp_n == 0)});
            check("err_cleared_on_start", {31'd0, err}, 32'd0);
         end
         if (stall_pend) begin
            check("stall_data_stable", {24'd0, out_data}, {24'd0, sd});
            check("stall_addr_stable", 32'(w_addr), 32'(sa));
         end
         stall_pend = 0;
         if (out_valid) check("no_in_ready_in_emit", {31'd0, in_ready}, 32'd0);
         if (!done && frame_done) begin
            done = 1;
            if (v.exp_n == 0) check("zero_frame_done_latency", cyc, 0);
            else if (!v.sdone) check("done_after_last_pixel", {31'd0, last_hs}, 32'd1);
         end
         if (done) begin
            after++;
            check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
            check("out_valid_in_done", {31'd0, out_valid}, 32'd0);
         end
         out_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
         last_hs = 0;
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_a.push_back(w_addr);
            last_hs = 1;
         end else if (out_valid) begin
            stall_pend = 1;
            sd = out_data;
            sa = w_addr;
         end
         if (used < v.nb) begin
            in_valid = 1'b1;
            in_data  = bytes[used];
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
         stream_done = v.sdone && (used >= v.nb);
         if (in_valid && in_ready) used++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; stream_done = 1'b0; out_ready = 1'b0; in_data = '0;
      check("frame_done_reached", {31'd0, done}, 32'd1);
      check("pixel_count", got_d.size(), v.exp_n);
      for (int k = 0; k < got_d.size() && k < v.exp_n; k++) begin
         exp_d = (k < v.split) ? v.v0 : v.v1;
         check("pixel_data", {24'd0, got_d[k]}, {24'd0, exp_d});
         check("pixel_addr", 32'(got_a[k]), k);
      end
      check("err_flag", {31'd0, err}, {31'd0, v.exp_err});
      check("bytes_consumed", used, v.exp_used);
      check("frame_done_level", {31'd0, frame_done}, 32'd1);
      $display("vec %0d: w=%0d h=%0d pixels=%0d last_addr=%0d err=%0b bytes=%0d",
               idx, v.w, v.h, got_d.size(), w_addr, err, used);
   endtask

   task automatic clear_mid_run();
      logic [3:0][7:0] bytes;
      int used = 0;
      bit hit = 0;
      bytes = 32'h5507AA03;
      @(posedge clk); #1;
      start = 1'b1; width = 16'd4; height = 16'd2;
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 60 && !hit; c++) begin
         if (out_valid && w_addr == 18'd5) begin
            hit = 1;
         end else begin
            in_valid = (used < 4);
            in_data  = (used < 4) ? bytes[used] : 8'h00;
            if (in_valid && in_ready) used++;
            @(posedge clk); #1;
         end
      end
      check("clear_reached_addr5", {31'd0, hit}, 32'd1);
      clear = 1'b1; start = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("clear_out_data", {24'd0, out_data}, 32'd0);
      check("clear_out_valid", {31'd0, out_valid}, 32'd0);
      check("clear_w_addr", 32'(w_addr), 32'd0);
      check("clear_in_ready", {31'd0, in_ready}, 32'd0);
      check("clear_frame_done", {31'd0, frame_done}, 32'd0);
      check("clear_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1;
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
      $display("clear: mid-run clear at w_addr 5, outputs w_addr=%0d out_valid=%0b", w_addr, out_valid);
   endtask

   initial begin
      tbl[0] = '{w:16'd0,  h:16'd5, nb:0, b:32'h0,        sdone:1'b0, toggle:1'b0,
                 exp_n:0,   v0:8'h00, split:0,   v1:8'h00, exp_err:1'b0, exp_used:0};
      tbl[1] = '{w:16'd4,  h:16'd2, nb:4, b:32'h5507AA03, sdone:1'b0, toggle:1'b0,
                 exp_n:12,  v0:8'hAA, split:4,   v1:8'h55, exp_err:1'b0, exp_used:4};
      tbl[2] = '{w:16'd4,  h:16'd2, nb:4, b:32'h5507AA03, sdone:1'b0, toggle:1'b1,
                 exp_n:12,  v0:8'hAA, split:4,   v1:8'h55, exp_err:1'b0, exp_used:4};
      tbl[3] = '{w:16'd4,  h:16'd2, nb:4, b:32'h0201110F, sdone:1'b0, toggle:1'b0,
                 exp_n:12,  v0:8'h11, split:12,  v1:8'h11, exp_err:1'b1, exp_used:2};
      tbl[4] = '{w:16'd4,  h:16'd2, nb:2, b:32'h00002203, sdone:1'b1, toggle:1'b0,
                 exp_n:4,   v0:8'h22, split:4,   v1:8'h22, exp_err:1'b1, exp_used:2};
      tbl[5] = '{w:16'd2,  h:16'd2, nb:2, b:32'h00007705, sdone:1'b0, toggle:1'b0,
                 exp_n:6,   v0:8'h77, split:6,   v1:8'h77, exp_err:1'b0, exp_used:2};
      tbl[6] = '{w:16'd3,  h:16'd1, nb:4, b:32'h44013301, sdone:1'b0, toggle:1'b0,
                 exp_n:4,   v0:8'h33, split:2,   v1:8'h44, exp_err:1'b0, exp_used:4};
      tbl[7] = '{w:16'd16, h:16'd16, nb:4, b:32'h6B7F5AFF, sdone:1'b0, toggle:1'b0,
                 exp_n:384, v0:8'h5A, split:256, v1:8'h6B, exp_err:1'b0, exp_used:4};

      clear = 1'b1; start = 1'b0; width = '0; height = '0;
      in_data = '0; in_valid = 1'b0; stream_done = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      check("reset_w_addr", 32'(w_addr), 32'd0);
      check("reset_out_data", {24'd0, out_data}, 32'd0);
      check("reset_frame_done", {31'd0, frame_done}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      clear = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (i == 5) clear_mid_run();
         run_vec(tbl[i], i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/rle_pixel_expander.md
Name: rle_pixel_expander

Overview:
- Downstream stage of the 18-bit read-address counter in the decompressor.
- Consumes the compressed byte stream fetched from the compressed-image memory at the counter's addresses, and drives that counter's count enable back through in_ready.
- Expands run-length pairs into a YUV 4:2:0 pixel byte stream, and generates the matching 18-bit write address into the decompressed frame buffer.
- Flags frame completion and stream errors.

Parameters:
- ADDR_W, 18, width of write address and frame byte count.
- DATA_W, 8, width of stream and pixel bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse to begin a frame; honoured only in IDLE or DONE.
- width  in  16  frame width in luma pixels, sampled on accepted start.
- height  in  16  frame height in luma pixels, sampled on accepted start.
- in_data  in  DATA_W  compressed byte from memory.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready; drives upstream counter count_en.
- stream_done  in  1  upstream counter count_done, i.e. no more compressed bytes.
- out_data  out  DATA_W  expanded pixel byte.
- out_valid  out  1  out_data/w_addr valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- w_addr  out  ADDR_W  frame-buffer write address of current out_data.
- frame_done  out  1  level, high in DONE.
- err  out  1  sticky error: run overran frame, or stream ended short.

Behaviour:
- Reset: clear high at a clock edge puts FSM in IDLE. Same edge: w_addr=0, out_data=0, out_valid=0, in_ready=0, frame_done=0, err=0, len/value/remaining registers=0. clear overrides start and every handshake, including mid-run.
- Frame size: total = (width*height*3)>>1, computed at full precision, then truncated to ADDR_W bits. Latched into total_r on accepted start.
- Pair format: byte 0 = L, byte 1 = V. Emits V exactly L+1 times (1..256).
- IDLE: in_ready=0, out_valid=0. On start:
  - w_addr←0, err←0, latch total_r.
  - If total==0, go to DONE; otherwise go to GET_LEN.
- GET_LEN: in_ready=1.
  - On in_valid: len←in_data, go to GET_VAL.
  - Else if stream_done: err←1, go to DONE (stream short).
- GET_VAL: in_ready=1.
  - On in_valid: value←in_data, remaining←len+1 (9 bits), go to EMIT.
  - Else if stream_done: err←1, go to DONE.
- EMIT: in_ready=0, out_valid=1, out_data=value, w_addr=current address. Stall while out_ready=0; outputs hold stable. On handshake:
  - If w_addr==total_r-1: go to DONE; if remaining!=1, err←1 (overrun, excess pixels dropped).
  - Else if remaining==1: w_addr+1, go to GET_LEN.
  - Else: w_addr+1, remaining-1, stay in EMIT.
- Throughput: one pixel per cycle while out_ready is held high. Each pair costs 2 accept cycles. No combinational path from in_valid to out_valid.
- DONE: frame_done=1, in_ready=0, out_valid=0, w_addr holds last written address. A new start reruns the frame exactly as from IDLE; frame_done drops next cycle.
- start outside IDLE/DONE is ignored.
- stream_done is not sampled in EMIT. Extra compressed bytes after frame end are never accepted.

Decomposition:
- Shared header (decomp_defs.vh):
  - FSM state encodings IDLE/GET_LEN/GET_VAL/EMIT/DONE (3-bit).
  - ADDR_W/DATA_W defaults.
  - Frame-size macro width*height*3/2, so the same frame-size expression serves the read counter.
- One sub-module: wr_addr_counter (load-zero, increment, terminal compare against total_r, returns is_last).

Test Plan:
- width=4, height=2 (total=12); stream 0x03,0xAA,0x07,0x55; out_ready=1 -> 4×0xAA at w_addr 0-3, 8×0x55 at 4-11; frame_done=1 in cycle after w_addr 11 handshake; err=0.
- Same stream, out_ready toggling 1/0 every cycle -> identical sequence, out_data/w_addr stable during stalls, no in_ready high in EMIT.
- total=12, stream 0x0F,0x11 -> 12×0x11 (w_addr 0-11), DONE, err=1; remaining bytes never accepted.
- total=12, stream 0x03,0x22 then stream_done=1, in_valid=0 -> 4 pixels, then DONE with err=1.
- clear asserted during EMIT at w_addr=5 -> next cycle all outputs 0, IDLE. Subsequent start with width=2, height=2 (total=6) and stream 0x05,0x77 -> 6×0x77 at 0-5, err=0.
- width=0 start -> DONE next cycle, no in_ready. start in DONE with width=4, height=2 -> frame reruns, frame_done low for duration.
